// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Control unit for the ALU system datapath. Fetches each
//             instruction in two byte cycles, executes it in one or two
//             cycles, and parks in HALT on the halt opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALU_FlagsOut,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic        IR_Write,
    output logic        IR_LH,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic [2:0]  T,
    output logic        Halted
);

    // State codes double as the debug T output.
    localparam logic [2:0] c_S_INIT    = 3'd0;
    localparam logic [2:0] c_S_FETCH_L = 3'd1;
    localparam logic [2:0] c_S_FETCH_H = 3'd2;
    localparam logic [2:0] c_S_EXEC1   = 3'd3;
    localparam logic [2:0] c_S_EXEC2   = 3'd4;
    localparam logic [2:0] c_S_HALT    = 3'd7;

    localparam logic [5:0] c_OP_BRA  = 6'h00;
    localparam logic [5:0] c_OP_BNE  = 6'h01;
    localparam logic [5:0] c_OP_BEQ  = 6'h02;
    localparam logic [5:0] c_OP_INC  = 6'h05;
    localparam logic [5:0] c_OP_DEC  = 6'h06;
    localparam logic [5:0] c_OP_ADD  = 6'h07;
    localparam logic [5:0] c_OP_SUB  = 6'h08;
    localparam logic [5:0] c_OP_AND  = 6'h09;
    localparam logic [5:0] c_OP_ORR  = 6'h0A;
    localparam logic [5:0] c_OP_XOR  = 6'h0B;
    localparam logic [5:0] c_OP_MOVL = 6'h10;

    localparam logic [2:0] c_RF_DEC   = 3'b000;
    localparam logic [2:0] c_RF_INC   = 3'b001;
    localparam logic [2:0] c_RF_LOAD  = 3'b010;
    localparam logic [2:0] c_RF_CLEAR = 3'b011;

    localparam logic [1:0] c_ARF_INC   = 2'b01;
    localparam logic [1:0] c_ARF_LOAD  = 2'b10;
    localparam logic [1:0] c_ARF_CLEAR = 2'b11;
    localparam logic [2:0] c_ARF_PC    = 3'b100;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    // Instruction fields, valid from EXEC1 onward.
    logic [5:0] w_op;
    logic       w_s;
    logic [2:0] w_dst;
    logic [2:0] w_sr1;
    logic [2:0] w_sr2;
    logic [1:0] w_rsel;
    logic       w_z;
    logic       w_flags_unused;

    assign w_op           = IROut[15:10];
    assign w_s            = IROut[9];
    assign w_dst          = IROut[8:6];
    assign w_sr1          = IROut[5:3];
    assign w_sr2          = IROut[2:0];
    assign w_rsel         = IROut[9:8];
    assign w_z            = ALU_FlagsOut[3];
    assign w_flags_unused = ^ALU_FlagsOut[2:0];

    // R1 sits in the MSB of RF_RegSel, R4 in the LSB.
    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        f_onehot = 4'b1000 >> idx;
    endfunction

    // State register; reset wins over every state including HALT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        w_next_state = c_S_INIT;
        RF_OutASel   = '0;
        RF_OutBSel   = '0;
        RF_FunSel    = '0;
        RF_RegSel    = '0;
        RF_ScrSel    = '0;
        ARF_RegSel   = '0;
        ARF_FunSel   = '0;
        ARF_OutCSel  = '0;
        ARF_OutDSel  = '0;
        ALU_FunSel   = '0;
        ALU_WF       = 1'b0;
        MuxASel      = '0;
        MuxBSel      = '0;
        MuxCSel      = '0;
        MuxDSel      = 1'b0;
        IR_Write     = 1'b0;
        IR_LH        = 1'b0;
        Mem_CS       = 1'b1;
        Mem_WR       = 1'b0;
        DR_E         = 1'b0;
        DR_FunSel    = '0;
        T            = r_state;
        Halted       = 1'b0;

        case (r_state)
            c_S_INIT: begin
                ARF_RegSel   = c_ARF_PC;
                ARF_FunSel   = c_ARF_CLEAR;
                RF_RegSel    = 4'b1111;
                RF_FunSel    = c_RF_CLEAR;
                w_next_state = c_S_FETCH_L;
            end

            c_S_FETCH_L, c_S_FETCH_H: begin
                Mem_CS       = 1'b0;
                Mem_WR       = 1'b0;
                ARF_OutDSel  = 2'b00;
                IR_Write     = 1'b1;
                IR_LH        = (r_state == c_S_FETCH_H);
                ARF_RegSel   = c_ARF_PC;
                ARF_FunSel   = c_ARF_INC;
                w_next_state = (r_state == c_S_FETCH_H) ? c_S_EXEC1 : c_S_FETCH_H;
            end

            c_S_EXEC1: begin
                w_next_state = c_S_FETCH_L;
                if (w_op == HALT_OPCODE) begin
                    w_next_state = c_S_HALT;
                end else begin
                    case (w_op)
                        c_OP_BRA, c_OP_BNE, c_OP_BEQ: begin
                            if ((w_op == c_OP_BRA) ||
                                (w_op == c_OP_BNE && !w_z) ||
                                (w_op == c_OP_BEQ &&  w_z)) begin
                                ARF_RegSel = c_ARF_PC;
                                ARF_FunSel = c_ARF_LOAD;
                                MuxBSel    = 2'b11;
                            end
                        end
                        c_OP_INC, c_OP_DEC: begin
                            // Copy SR1 into DST now, adjust DST in EXEC2.
                            if (w_dst[2] && w_sr1[2]) begin
                                ALU_FunSel   = 5'b10000;
                                MuxDSel      = 1'b0;
                                RF_OutASel   = {1'b0, w_sr1[1:0]};
                                MuxASel      = 2'b00;
                                RF_RegSel    = f_onehot(w_dst[1:0]);
                                RF_FunSel    = c_RF_LOAD;
                                w_next_state = c_S_EXEC2;
                            end
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_ORR, c_OP_XOR: begin
                            if (w_dst[2] && w_sr1[2] && w_sr2[2]) begin
                                case (w_op)
                                    c_OP_ADD: ALU_FunSel = 5'b10100;
                                    c_OP_SUB: ALU_FunSel = 5'b10110;
                                    c_OP_AND: ALU_FunSel = 5'b10111;
                                    c_OP_ORR: ALU_FunSel = 5'b11000;
                                    default:  ALU_FunSel = 5'b11001;
                                endcase
                                RF_OutASel = {1'b0, w_sr1[1:0]};
                                RF_OutBSel = {1'b0, w_sr2[1:0]};
                                MuxDSel    = 1'b0;
                                ALU_WF     = w_s;
                                MuxASel    = 2'b00;
                                RF_RegSel  = f_onehot(w_dst[1:0]);
                                RF_FunSel  = c_RF_LOAD;
                            end
                        end
                        c_OP_MOVL: begin
                            MuxASel   = 2'b11;
                            RF_RegSel = f_onehot(w_rsel);
                            RF_FunSel = c_RF_LOAD;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            c_S_EXEC2: begin
                RF_RegSel    = f_onehot(w_dst[1:0]);
                RF_FunSel    = (w_op == c_OP_INC) ? c_RF_INC : c_RF_DEC;
                w_next_state = c_S_FETCH_L;
            end

            c_S_HALT: begin
                Halted       = 1'b1;
                w_next_state = c_S_HALT;
            end

            default: begin
                w_next_state = c_S_INIT;
            end
        endcase

        // While reset is asserted no storage element may be written, so an
        // interrupted EXEC2 (or any other state) never commits its update.
        if (Reset) begin
            RF_RegSel  = '0;
            ARF_RegSel = '0;
            IR_Write   = 1'b0;
            ALU_WF     = 1'b0;
            DR_E       = 1'b0;
            Mem_CS     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Randomized self-checking bench for control_sequencer against
//             an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    typedef struct packed {
        logic [2:0] a_sel;
        logic [2:0] b_sel;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] scr;
        logic [2:0] arf_reg;
        logic [1:0] arf_fun;
        logic [1:0] outc;
        logic [1:0] outd;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic [1:0] mux_c;
        logic       mux_d;
        logic       ir_w;
        logic       ir_lh;
        logic       cs;
        logic       wr;
        logic       dr_e;
        logic [1:0] dr_fun;
        logic [2:0] t;
        logic       halted;
    } outs_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALU_FlagsOut;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  ARF_FunSel, ARF_OutCSel, ARF_OutDSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  MuxASel, MuxBSel, MuxCSel;
    logic        MuxDSel, IR_Write, IR_LH, Mem_CS, Mem_WR, DR_E;
    logic [1:0]  DR_FunSel;
    logic [2:0]  T;
    logic        Halted;

    int n_checks = 0;
    int n_fail   = 0;

    outs_t obs;
    outs_t exp_q[$];
    string tag_q[$];

    control_sequencer dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALU_FlagsOut(ALU_FlagsOut),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ARF_RegSel(ARF_RegSel),
        .ARF_FunSel(ARF_FunSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .MuxDSel(MuxDSel), .IR_Write(IR_Write), .IR_LH(IR_LH),
        .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .DR_E(DR_E), .DR_FunSel(DR_FunSel),
        .T(T), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ARF_RegSel,
                  ARF_FunSel, ARF_OutCSel, ARF_OutDSel, ALU_FunSel, ALU_WF, MuxASel,
                  MuxBSel, MuxCSel, MuxDSel, IR_Write, IR_LH, Mem_CS, Mem_WR, DR_E,
                  DR_FunSel, T, Halted};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic outs_t m_idle(input int t);
        outs_t o = '0;
        o.cs = 1'b1;
        o.t  = 3'(t);
        return o;
    endfunction

    function automatic outs_t m_init();
        outs_t o = m_idle(0);
        o.arf_reg = 3'b100; o.arf_fun = 2'b11;
        o.rf_reg  = 4'b1111; o.rf_fun = 3'b011;
        return o;
    endfunction

    function automatic outs_t m_fetch(input bit hi);
        outs_t o = m_idle(hi ? 2 : 1);
        o.cs = 1'b0; o.ir_w = 1'b1; o.ir_lh = hi;
        o.arf_reg = 3'b100; o.arf_fun = 2'b01;
        return o;
    endfunction

    function automatic outs_t m_halt();
        outs_t o = m_idle(7);
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic outs_t m_no_writes(input outs_t i);
        outs_t o = i;
        o.rf_reg = '0; o.arf_reg = '0; o.ir_w = 1'b0;
        o.alu_wf = 1'b0; o.dr_e = 1'b0; o.cs = 1'b1;
        return o;
    endfunction

    // Register number 1..4 for a 3-bit register code, 0 when illegal.
    function automatic int reg_num(input int code);
        return (code >= 4) ? code - 3 : 0;
    endfunction

    function automatic logic [3:0] sel_of(input int rnum);
        logic [3:0] tab [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        return tab[rnum - 1];
    endfunction

    // Queue the whole expected cycle sequence for one instruction.
    task automatic plan_instr(input logic [15:0] ir, input logic [3:0] flags);
        int op   = int'(ir) / 1024;
        int s    = (int'(ir) / 512) % 2;
        int dst  = (int'(ir) / 64) % 8;
        int sr1  = (int'(ir) / 8) % 8;
        int sr2  = int'(ir) % 8;
        int rsel = (int'(ir) / 256) % 4;
        bit z    = flags[3];
        outs_t e = m_idle(3);
        outs_t e2;
        bit two = 1'b0, halt = 1'b0;
        exp_q.push_back(m_fetch(1'b0)); tag_q.push_back($sformatf("FETCH_L ir=%h", ir));
        exp_q.push_back(m_fetch(1'b1)); tag_q.push_back($sformatf("FETCH_H ir=%h", ir));
        if (op == 63) begin
            halt = 1'b1;
        end else if (op == 0 || (op == 1 && !z) || (op == 2 && z)) begin
            e.arf_reg = 3'b100; e.arf_fun = 2'b10; e.mux_b = 2'b11;
        end else if ((op == 5 || op == 6) && reg_num(dst) > 0 && reg_num(sr1) > 0) begin
            e.alu_fun = 5'b10000;
            e.a_sel   = 3'(reg_num(sr1) - 1);
            e.rf_reg  = sel_of(reg_num(dst));
            e.rf_fun  = 3'b010;
            two = 1'b1;
        end else if (op >= 7 && op <= 11 && reg_num(dst) > 0 && reg_num(sr1) > 0 && reg_num(sr2) > 0) begin
            case (op)
                7:       e.alu_fun = 5'b10100;
                8:       e.alu_fun = 5'b10110;
                9:       e.alu_fun = 5'b10111;
                10:      e.alu_fun = 5'b11000;
                default: e.alu_fun = 5'b11001;
            endcase
            e.a_sel  = 3'(reg_num(sr1) - 1);
            e.b_sel  = 3'(reg_num(sr2) - 1);
            e.alu_wf = s[0];
            e.rf_reg = sel_of(reg_num(dst));
            e.rf_fun = 3'b010;
        end else if (op == 16) begin
            e.mux_a  = 2'b11;
            e.rf_reg = sel_of(rsel + 1);
            e.rf_fun = 3'b010;
        end
        exp_q.push_back(e); tag_q.push_back($sformatf("EXEC1 ir=%h", ir));
        if (two) begin
            e2 = m_idle(4);
            e2.rf_reg = sel_of(reg_num(dst));
            e2.rf_fun = (op == 5) ? 3'b001 : 3'b000;
            exp_q.push_back(e2); tag_q.push_back($sformatf("EXEC2 ir=%h", ir));
        end
        if (halt) begin
            for (int k = 0; k < 10; k++) begin
                exp_q.push_back(m_halt()); tag_q.push_back("HALT_HOLD");
            end
        end
    endtask

    // Apply one instruction from FETCH_L and check up to max_cycles cycles.
    task automatic run_instr(input logic [15:0] ir, input logic [3:0] flags, input int max_cycles);
        int n = 0;
        IROut = ir;
        ALU_FlagsOut = flags;
        exp_q.delete();
        tag_q.delete();
        plan_instr(ir, flags);
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(negedge Clock);
            check_val(tag_q.pop_front(), 64'(obs), 64'(exp_q.pop_front()));
            @(posedge Clock); #1;
            n++;
        end
    endtask

    initial begin
        logic [15:0] ir;
        int pick;
        logic [5:0] ops [11] = '{6'h00, 6'h01, 6'h02, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h10};
        Reset = 1'b1;
        IROut = '0;
        ALU_FlagsOut = '0;

        // Reset held: state is INIT but no writes may be issued.
        @(posedge Clock); #1;
        @(negedge Clock);
        check_val("RESET_HELD", 64'(obs), 64'(m_no_writes(m_init())));
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_val("INIT", 64'(obs), 64'(m_init()));
        @(posedge Clock); #1;

        run_instr(16'h415A, 4'b0000, 100);
        run_instr(16'h1FA5, 4'b0000, 100);
        run_instr(16'h0833, 4'b1000, 100);
        run_instr(16'h0833, 4'b0000, 100);
        run_instr(16'h15E0, 4'b0000, 100);
        run_instr(16'h19E0, 4'b0000, 100);
        run_instr(16'h1C25, 4'b0000, 100);
        run_instr(16'h0433, 4'b1000, 100);
        run_instr(16'h0433, 4'b0000, 100);

        for (int i = 0; i < 80; i++) begin
            pick = int'($urandom_range(0, 12));
            ir = 16'($urandom);
            if (pick < 11) ir[15:10] = ops[pick];
            else           ir[15:10] = 6'($urandom_range(0, 62));
            if ($urandom_range(0, 1) == 1) ir = ir | 16'h0124;
            run_instr(ir, 4'($urandom), 100);
        end

        // Reset arriving during EXEC2 must suppress the RF update.
        run_instr(16'h15E0, 4'b0000, 3);
        Reset = 1'b1;
        @(negedge Clock);
        begin
            outs_t e2 = m_idle(4);
            e2.rf_fun = 3'b001;
            check_val("RST_IN_EXEC2", 64'(obs), 64'(e2));
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_val("INIT_AFTER_RST", 64'(obs), 64'(m_init()));
        @(posedge Clock); #1;

        // Halt and hold, then reset out of HALT.
        run_instr(16'hFC00, 4'b0000, 100);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_val("INIT_FROM_HALT", 64'(obs), 64'(m_init()));
        @(posedge Clock); #1;
        run_instr(16'h4A11, 4'b0000, 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Control unit that drives every control input of the ALU system datapath: RF, ARF, ALU, DR, IR, memory and Mux A/B/C/D selects.
- Receives IROut and ALU_FlagsOut back from the datapath.
- Sequences each instruction through two fetch cycles (IR low byte, then high byte), one or two execute cycles, and a halt state.

Parameters:
HALT_OPCODE, 6'h3F, opcode that enters HALT

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
IROut  input  16  instruction register contents
ALU_FlagsOut  input  4  {Z,C,N,O}, bit3=Z
RF_OutASel, RF_OutBSel  output  3 each  000-011 select R1-R4
RF_FunSel  output  3  000 dec, 001 inc, 010 load, 011 clear
RF_RegSel  output  4  one-hot active-high, bit3=R1 ... bit0=R4
RF_ScrSel  output  4  scratch select, always 0000
ARF_RegSel  output  3  active-high, bit2=PC, bit1=AR, bit0=SP
ARF_FunSel  output  2  00 dec, 01 inc, 10 load, 11 clear
ARF_OutCSel, ARF_OutDSel  output  2 each  00=PC
ALU_FunSel  output  5  ALU operation code
ALU_WF  output  1  flag write enable
MuxASel, MuxBSel, MuxCSel  output  2 each  mux selects
MuxDSel  output  1  mux select
IR_Write, IR_LH  output  1 each  IR load enable and byte select
Mem_CS  output  1  chip select, active-low
Mem_WR  output  1  1=write, 0=read
DR_E  output  1  DR enable
DR_FunSel  output  2  DR function
T  output  3  state code (debug)
Halted  output  1  high in HALT

Behaviour:
- One clock. Reset is synchronous and active-high.
- All outputs are combinational from registered state and IROut.
- Idle defaults, used unless a state overrides them:
  - RF_RegSel=0000, ARF_RegSel=000, IR_Write=0, ALU_WF=0, DR_E=0.
  - Mem_CS=1, Mem_WR=0.
  - All selects and FunSels 0.
- Reset: state=INIT on the next edge. T encodes INIT=0, FETCH_L=1, FETCH_H=2, EXEC1=3, EXEC2=4, HALT=7. Reset overrides every state, including mid-EXEC2 and HALT.
- INIT (1 cycle): clear PC (ARF_RegSel=100, ARF_FunSel=11) and R1-R4 (RF_RegSel=1111, RF_FunSel=011). Next state FETCH_L.
- FETCH_L: Mem_CS=0, Mem_WR=0, ARF_OutDSel=00, IR_Write=1, IR_LH=0; PC increment (ARF_RegSel=100, ARF_FunSel=01). Next state FETCH_H.
- FETCH_H: same as FETCH_L with IR_LH=1. Next state EXEC1. IROut holds the full instruction from EXEC1 onward.
- Instruction format: op=IR[15:10], S=IR[9], DST=IR[8:6], SR1=IR[5:3], SR2=IR[2:0], VAL=IR[7:0], RSEL=IR[9:8].
- Register fields: codes 1xx map to R1-R4 (index=low 2 bits). Codes 0xx are illegal: EXEC1 performs no writes and returns to FETCH_L.
- EXEC1 by opcode:
  - 0x00 BRA: PC<=VAL. ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11.
  - 0x01 BNE: as BRA if Z=0, otherwise no writes.
  - 0x02 BEQ: as BRA if Z=1, otherwise no writes.
  - 0x05 INC / 0x06 DEC: DST<=SR1 via ALU pass-A. ALU_FunSel=10000, MuxDSel=0, RF_OutASel=SR1, MuxASel=00, RF_RegSel=onehot(DST), RF_FunSel=010. Next state EXEC2.
  - 0x07 ADD (10100), 0x08 SUB (10110), 0x09 AND (10111), 0x0A ORR (11000), 0x0B XOR (11001): RF_OutASel=SR1, RF_OutBSel=SR2, MuxDSel=0, ALU_WF=S, MuxASel=00, load into DST.
  - 0x10 MOVL: R[RSEL]<=zero-extended VAL. MuxASel=11, RF_FunSel=010.
  - HALT_OPCODE: no writes. Next state HALT.
  - Any other opcode: NOP.
  - All except INC/DEC and HALT return to FETCH_L.
- EXEC2 (INC/DEC only): RF_RegSel=onehot(DST), RF_FunSel=001 (INC) or 000 (DEC). Next state FETCH_L.
- HALT: idle outputs, Halted=1, T=7. Held until Reset.
- Latency: 4 cycles per instruction for INC/DEC, 3 cycles for all others.
- Branch condition samples ALU_FlagsOut during EXEC1.

Test Plan:
- Reset high 2 cycles, then low -> INIT: ARF_RegSel=100, ARF_FunSel=11, RF_RegSel=1111, RF_FunSel=011. Next cycle FETCH_L: Mem_CS=0, IR_Write=1, IR_LH=0, ARF_FunSel=01. Then FETCH_H with IR_LH=1.
- IROut=0x415A (MOVL R2,0x5A) -> EXEC1: MuxASel=11, RF_RegSel=0100, RF_FunSel=010. Next state FETCH_L.
- IROut=0x1FA5 (ADD R3=R1+R2, S=1) -> EXEC1: RF_OutASel=000, RF_OutBSel=001, ALU_FunSel=10100, ALU_WF=1, RF_RegSel=0010, RF_FunSel=010.
- IROut=0x0833 (BEQ 0x33): flags=4'b1000 -> ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11. Flags=4'b0000 -> ARF_RegSel=000 and RF_RegSel=0000.
- IROut=0x15E0 (INC R4<-R1) -> EXEC1: ALU_FunSel=10000, RF_RegSel=0001, RF_FunSel=010. EXEC2: RF_RegSel=0001, RF_FunSel=001.
- Other cases:
  - IROut=0x1C25 (DST=000) -> no writes, back to FETCH_L.
  - IROut=0xFC00 -> HALT, Halted=1 and held over 10 cycles.
  - Reset asserted during EXEC2 of an INC -> no RF write that cycle; INIT follows.
